// File: rtl/pipe_gap_gen.sv
// Pipe gap generator: keeps eight packed gap-centre Y lanes and shifts in a fresh
// LFSR-derived value on every column scroll. Optional slew limit: PIPE_GAP_SLEW_LIMIT_EN.
module pipe_gap_gen #(
  parameter int unsigned GAP_MIN    = 40,
  parameter int unsigned GAP_MAX    = 200,
  parameter int unsigned SCROLL_DIV = 64,
  parameter int unsigned MAX_STEP   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        frame_tick,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [63:0] data_out,
  output logic        ena_out,
  output logic        overrun
);

  localparam int unsigned RANGE     = GAP_MAX - GAP_MIN + 1;
  localparam int unsigned CNT_W     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [8:0]  RANGE9    = 9'(RANGE);
  localparam logic [7:0]  GAP_MIN8  = 8'(GAP_MIN);
  localparam logic [7:0]  MID8      = 8'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

  if ((GAP_MAX < GAP_MIN) || (GAP_MAX > 255) || (RANGE > 256) ||
      (SCROLL_DIV < 1) || (MAX_STEP > 255)) begin : g_bad_params
    $error("pipe_gap_gen: parameter set out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GEN,
    S_REDUCE,
    S_PUSH
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic [CNT_W-1:0] frame_cnt;
  logic             pending;
  logic [8:0]       cand;
  logic             scroll_evt;
  logic             busy;
  logic [7:0]       raw_lane;
  logic [7:0]       push_lane;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign scroll_evt = run && frame_tick && (frame_cnt == CNT_LAST);
  assign busy       = (state == S_GEN) || (state == S_REDUCE) || (state == S_PUSH);
  assign raw_lane   = GAP_MIN8 + cand[7:0];

`ifdef PIPE_GAP_SLEW_LIMIT_EN
  localparam logic [9:0] STEP10 = 10'(MAX_STEP);
  localparam logic [9:0] MIN10  = 10'(GAP_MIN);
  localparam logic [9:0] MAX10  = 10'(GAP_MAX);

  logic [9:0] prev10;
  logic [9:0] raw10;
  logic [9:0] lo10;
  logic [9:0] hi10;

  // Window around the previous newest lane, intersected with the legal gap range
  always_comb begin
    prev10 = {2'b00, data_out[7:0]};
    raw10  = {2'b00, raw_lane};
    lo10   = (prev10 > STEP10) ? (prev10 - STEP10) : '0;
    if (lo10 < MIN10) lo10 = MIN10;
    hi10 = prev10 + STEP10;
    if (hi10 > MAX10) hi10 = MAX10;
    if (raw10 < lo10) begin
      push_lane = lo10[7:0];
    end else if (raw10 > hi10) begin
      push_lane = hi10[7:0];
    end else begin
      push_lane = raw_lane;
    end
  end
`else
  assign push_lane = raw_lane;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      data_out  <= {8{MID8}};
      ena_out   <= 1'b0;
      overrun   <= 1'b0;
      lfsr      <= LFSR_INIT;
      frame_cnt <= '0;
      pending   <= 1'b0;
      cand      <= '0;
    end else begin
      ena_out <= 1'b0;

      if (run && frame_tick) begin
        frame_cnt <= scroll_evt ? '0 : frame_cnt + CNT_W'(1);
      end

      if (scroll_evt && busy) begin
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end

      if (seed_load) begin
        lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
      end else if (state == S_PUSH) begin
        lfsr <= {lfsr_fb, lfsr[15:1]};
      end

      // Entering IDLE always drops a queued scroll; later assignments override the set above
      case (state)
        S_IDLE: begin
          if (run) state <= S_RUN;
        end
        S_RUN: begin
          if (!run) begin
            state   <= S_IDLE;
            pending <= 1'b0;
          end else if (scroll_evt || pending) begin
            state   <= S_GEN;
            pending <= 1'b0;
          end
        end
        S_GEN: begin
          if (!run) begin
            state   <= S_IDLE;
            pending <= 1'b0;
          end else begin
            cand  <= {1'b0, lfsr[7:0]};
            state <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (!run) begin
            state   <= S_IDLE;
            pending <= 1'b0;
          end else if (cand >= RANGE9) begin
            cand <= cand - RANGE9;
          end else begin
            state <= S_PUSH;
          end
        end
        S_PUSH: begin
          data_out <= {data_out[55:0], push_lane};
          ena_out  <= 1'b1;
          if (run) begin
            state <= S_RUN;
          end else begin
            state   <= S_IDLE;
            pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Randomised and directed bench for pipe_gap_gen; lane values come from a
// push-level model (LFSR sequence, modulo reduction, optional clamp).
module tb_pipe_gap_gen;

  localparam int GAP_MIN  = 40;
  localparam int GAP_MAX  = 200;
  localparam int RANGE    = GAP_MAX - GAP_MIN + 1;
  localparam int MAX_STEP = 16;
  localparam logic [63:0] MID_W = 64'h7878787878787878;
`ifdef PIPE_GAP_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif
  localparam logic [7:0] ZLANE = SLEW ? 8'd118 : 8'h68;
  localparam logic [7:0] SLANE = SLEW ? 8'h88 : 8'hC8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        frame_tick = 1'b0;
  logic        frame_tick_f = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [63:0] dout [2];
  logic        ena [2];
  logic        ovr [2];

  int n_checks = 0;
  int n_pass   = 0;

  pipe_gap_gen #(.GAP_MIN(40), .GAP_MAX(200), .SCROLL_DIV(4), .MAX_STEP(16)) u_dut (
    .clk(clk), .rst(rst), .run(run), .frame_tick(frame_tick), .seed_load(seed_load),
    .seed(seed), .data_out(dout[0]), .ena_out(ena[0]), .overrun(ovr[0])
  );

  pipe_gap_gen #(.GAP_MIN(40), .GAP_MAX(200), .SCROLL_DIV(1), .MAX_STEP(16)) u_fast (
    .clk(clk), .rst(rst), .run(run), .frame_tick(frame_tick_f), .seed_load(seed_load),
    .seed(seed), .data_out(dout[1]), .ena_out(ena[1]), .overrun(ovr[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int unsigned v = s;
    int unsigned b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [7:0] gap_of(input logic [15:0] s, input logic [7:0] prev);
    int v  = GAP_MIN + (int'(s[7:0]) % RANGE);
    int lo = int'(prev) - MAX_STEP;
    int hi = int'(prev) + MAX_STEP;
    if (lo < GAP_MIN) lo = GAP_MIN;
    if (hi > GAP_MAX) hi = GAP_MAX;
    if (SLEW) begin
      if (v < lo) v = lo;
      if (v > hi) v = hi;
    end
    return 8'(v);
  endfunction

  // Push-level model: one lane per ena_out pulse, seed loads take effect after that push
  logic [15:0] m_lfsr [2];
  logic [63:0] m_word [2];
  logic        m_prev_ena [2];
  int          push_cnt [2];
  logic        seed_pend;
  logic [15:0] seed_q;
  string       nm [2] = '{"dut_word", "fast_word"};

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_lfsr[i]     = 16'hACE1;
        m_word[i]     = MID_W;
        m_prev_ena[i] = 1'b0;
      end
      seed_pend = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ena[i]) begin
          m_word[i] = {m_word[i][55:0], gap_of(m_lfsr[i], m_word[i][7:0])};
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
          push_cnt[i]++;
        end
        chk(nm[i], dout[i], m_word[i]);
        chk("ena_single", {63'd0, ena[i] & m_prev_ena[i]}, 64'd0);
        m_prev_ena[i] = ena[i];
        if (seed_pend) m_lfsr[i] = (seed_q == 16'h0000) ? 16'hACE1 : seed_q;
      end
      seed_pend = seed_load;
      seed_q    = seed;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
  endtask

  task automatic wait_ena(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (ena[0]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          exp_lat;
    int          p0;
    logic [63:0] w;

    push_cnt[0] = 0;
    push_cnt[1] = 0;
    #1 rst = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("rst_word", dout[i], MID_W);
      chk("rst_ena", {63'd0, ena[i]}, 64'd0);
      chk("rst_ovr", {63'd0, ovr[i]}, 64'd0);
    end
    rst = 1'b0;
    cyc();

    // Seed 0x12FF: cand 255 needs one subtraction
    seed = 16'h12FF; seed_load = 1'b1; run = 1'b1;
    cyc();
    seed_load = 1'b0;
    ticks(4);
    wait_ena(lat);
    chk("seed_lat", lat, 4);
    chk("seed_word", dout[0], 64'h7878787878787886);
    cyc();
    chk("seed_ena_once", {63'd0, ena[0]}, 64'd0);

    // Zero seed falls back to 0xACE1
    seed = 16'h0000; seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    ticks(4);
    wait_ena(lat);
    chk("zero_lat", lat, 4);
    w = {56'h78787878787886, ZLANE};
    chk("zero_word", dout[0], w);

    // Abort in REDUCE, then resume from a held frame count
    ticks(4);
    cyc();
    run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("abort_no_ena", {63'd0, ena[0]}, 64'd0);
    end
    chk("abort_word", dout[0], w);
    run = 1'b1;
    ticks(2);
    run = 1'b0;
    ticks(3);
    run = 1'b1;
    cyc();
    ticks(2);
    exp_lat = (int'(m_lfsr[0][7:0]) >= RANGE) ? 4 : 3;
    wait_ena(lat);
    chk("resume_lat", lat, exp_lat);

    // Back-to-back scrolls on the SCROLL_DIV=1 instance
    chk("fast_ovr_pre", {63'd0, ovr[1]}, 64'd0);
    p0 = push_cnt[1];
    frame_tick_f = 1'b1;
    repeat (60) cyc();
    frame_tick_f = 1'b0;
    chk("fast_ovr_set", {63'd0, ovr[1]}, 64'd1);
    chk("fast_pushes_ge8", {63'd0, (push_cnt[1] - p0) >= 8}, 64'd1);
    chk("dut_ovr_clear", {63'd0, ovr[0]}, 64'd0);
    repeat (6) cyc();
    chk("fast_ovr_sticky", {63'd0, ovr[1]}, 64'd1);

    // Asynchronous reset while busy
    frame_tick_f = 1'b1;
    repeat (5) cyc();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_word", dout[i], MID_W);
      chk("arst_ena", {63'd0, ena[i]}, 64'd0);
      chk("arst_ovr", {63'd0, ovr[i]}, 64'd0);
    end
    frame_tick_f = 1'b0;
    cyc();
    rst = 1'b0;

    // Slew case: cand 160 -> 200 against previous lane 120
    seed = 16'h00A0; seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    ticks(4);
    wait_ena(lat);
    chk("slew_lat", lat, 3);
    chk("slew_word", dout[0], {56'h78787878787878, SLANE});

    // Random run/tick traffic with occasional reseeds while idle
    p0 = push_cnt[0];
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 99) < 3) begin
        frame_tick = 1'b0; frame_tick_f = 1'b0; run = 1'b0;
        repeat (3) cyc();
        seed = 16'($urandom); seed_load = 1'b1;
        cyc();
        seed_load = 1'b0; run = 1'b1;
      end else begin
        run          = ($urandom_range(0, 15) != 0);
        frame_tick   = ($urandom_range(0, 2) == 0);
        frame_tick_f = frame_tick;
        cyc();
      end
    end
    frame_tick = 1'b0; frame_tick_f = 1'b0; run = 1'b0;
    repeat (8) cyc();
    chk("rand_pushes", {63'd0, (push_cnt[0] - p0) > 20}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
